hex_disp_writer: RTL and testbench

HEX_DISP_WRITER -- requirements
Module: hex_disp_writer

---
 rtl/hex_disp_writer_pkg.sv | 30 +++
 rtl/hex_disp_writer_hex7_enc.sv | 32 +++
 rtl/hex_disp_writer.sv | 125 ++++++++++++
 tb/tb_hex_disp_writer.sv | 139 +++++++++++++
 4 files changed

// File: rtl/hex_disp_writer_pkg.sv
// Shared display constants: FSM encoding, digit count and the 7-segment
// active-high patterns (bit0=a .. bit6=g).
package hex_disp_writer_pkg;

  localparam int NUM_DIGITS = 6;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/hex_disp_writer_hex7_enc.sv
// Combinational nibble to active-high 7-segment pattern encoder.
module hex7_enc
  import hex_disp_writer_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_0;
    case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_0;
    endcase
  end

endmodule

// File: rtl/hex_disp_writer.sv
// Writes a captured hex value, one digit per cycle, into a 6-entry display
// register file with optional leading-zero suppression.
module hex_disp_writer #(
  parameter int NUM_DIGITS = hex_disp_writer_pkg::NUM_DIGITS
) (
  input  logic                    Clock,
  input  logic                    Resetn,
  input  logic [4*NUM_DIGITS-1:0] Value,
  input  logic                    Blank,
  input  logic                    Start,
  output logic [6:0]              Data,
  output logic [2:0]              Addr,
  output logic                    Sel,
  output logic                    Busy,
  output logic                    Done
);
  import hex_disp_writer_pkg::*;

  localparam int VW = 4 * NUM_DIGITS;
  localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);

  logic [1:0]    state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [2:0]    addr_q, addr_d;
  logic [6:0]    data_q, data_d;
  logic          sel_q, sel_d;
  logic [VW-1:0] val_q, val_d;
  logic          blank_q, blank_d;

  // The first digit is registered on the capture edge itself, so it must be
  // encoded from the live inputs; later digits come from the captured copy.
  logic [VW-1:0]                 src_val;
  logic                          src_blank;
  logic [NUM_DIGITS-1:0][6:0]    seg;
  logic [NUM_DIGITS:0]           hi_zero;
  logic [2:0]                    nxt;
  logic [6:0]                    nxt_seg;

  assign src_val   = (state_q == ST_IDLE) ? Value : val_q;
  assign src_blank = (state_q == ST_IDLE) ? Blank : blank_q;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_enc
    hex7_enc u_enc (
      .nib (src_val[4*g +: 4]),
      .seg (seg[g])
    );
  end

  // hi_zero[k]: nibble k and every nibble above it are zero
  always_comb begin
    hi_zero = '0;
    hi_zero[NUM_DIGITS] = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--)
      hi_zero[k] = hi_zero[k+1] && (src_val[4*k +: 4] == 4'h0);
  end

  always_comb begin
    nxt     = (state_q == ST_IDLE) ? 3'd0 : 3'(idx_q + 3'd1);
    nxt_seg = seg[nxt];
    if (src_blank && (nxt != 3'd0) && hi_zero[nxt])
      nxt_seg = SEG_BLANK;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    data_d  = data_q;
    sel_d   = 1'b0;
    val_d   = val_q;
    blank_d = blank_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          val_d   = Value;
          blank_d = Blank;
          idx_d   = 3'd0;
          addr_d  = 3'd0;
          data_d  = nxt_seg;
          sel_d   = 1'b1;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d  = nxt;
          addr_d = nxt;
          data_d = nxt_seg;
          sel_d  = 1'b1;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      sel_q   <= 1'b0;
      val_q   <= '0;
      blank_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      val_q   <= val_d;
      blank_q <= blank_d;
    end
  end

  assign Data = data_q;
  assign Addr = addr_q;
  assign Sel  = sel_q;
  assign Busy = (state_q == ST_WRITE);
  assign Done = (state_q == ST_DONE);

endmodule

// File: tb/tb_hex_disp_writer.sv
// Directed bench for hex_disp_writer with hand-computed segment patterns.
module tb_hex_disp_writer;

  logic        Clock;
  logic        Resetn;
  logic [23:0] Value;
  logic        Blank;
  logic        Start;
  logic [6:0]  Data;
  logic [2:0]  Addr;
  logic        Sel;
  logic        Busy;
  logic        Done;

  int n_tests = 0;
  int n_fail  = 0;
  int sel_cnt = 0;

  hex_disp_writer #(.NUM_DIGITS(6)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .Value  (Value),
    .Blank  (Blank),
    .Start  (Start),
    .Data   (Data),
    .Addr   (Addr),
    .Sel    (Sel),
    .Busy   (Busy),
    .Done   (Done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Counts the Sel level of the cycle that just ended
  always @(posedge Clock) if (Sel === 1'b1) sel_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // ev[k] is the expected pattern for digit k
  task automatic run_seq(input string nm, input logic [23:0] v, input logic b,
                         input logic [5:0][6:0] ev, input bit repulse);
    int base;
    @(negedge Clock);
    base = sel_cnt;
    Value = v; Blank = b; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0; Value = ~v; Blank = ~b;
    for (int k = 0; k < 6; k++) begin
      chk({nm, "_sel"},  Sel,  1);
      chk({nm, "_busy"}, Busy, 1);
      chk({nm, "_addr"}, Addr, k);
      chk({nm, "_data"}, Data, ev[k]);
      if (repulse && k == 2) begin
        Start = 1'b1; Value = 24'h0F0F0F;
      end else begin
        Start = 1'b0;
      end
      @(negedge Clock);
    end
    chk({nm, "_done"},  Done, 1);
    chk({nm, "_dsel"},  Sel,  0);
    chk({nm, "_dbusy"}, Busy, 0);
    chk({nm, "_hold_addr"}, Addr, 5);
    chk({nm, "_hold_data"}, Data, ev[5]);
    @(negedge Clock);
    chk({nm, "_done_clr"}, Done, 0);
    repeat (3) @(negedge Clock);
    chk({nm, "_selcnt"}, sel_cnt - base, 6);
    chk({nm, "_idle"}, Sel, 0);
  endtask

  initial begin
    int base;
    Resetn = 1'b0; Start = 1'b0; Value = 24'h0; Blank = 1'b0;
    repeat (2) @(negedge Clock);
    chk("rst_data", Data, 0);
    chk("rst_addr", Addr, 0);
    chk("rst_sel",  Sel,  0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    Resetn = 1'b1;
    @(negedge Clock);

    run_seq("v123456", 24'h123456, 1'b0, {7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D}, 1'b0);
    run_seq("a0_blank", 24'h0000A0, 1'b1, {7'h00, 7'h00, 7'h00, 7'h00, 7'h77, 7'h3F}, 1'b0);
    run_seq("a0_noblank", 24'h0000A0, 1'b0, {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h77, 7'h3F}, 1'b0);
    run_seq("zero_blank", 24'h000000, 1'b1, {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h3F}, 1'b0);
    run_seq("fedcba", 24'hFEDCBA, 1'b1, {7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77}, 1'b0);
    run_seq("inner_zero", 24'h0F0000, 1'b1, {7'h00, 7'h71, 7'h3F, 7'h3F, 7'h3F, 7'h3F}, 1'b0);
    run_seq("repulse", 24'h123456, 1'b0, {7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D}, 1'b1);

    // Reset in the middle of the Addr=2 write
    @(negedge Clock);
    base = sel_cnt;
    Value = 24'h123456; Blank = 1'b0; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    repeat (2) @(negedge Clock);
    chk("abort_pre_addr", Addr, 2);
    chk("abort_pre_sel",  Sel,  1);
    #2 Resetn = 1'b0;
    #1;
    chk("abort_sel",  Sel,  0);
    chk("abort_busy", Busy, 0);
    chk("abort_done", Done, 0);
    chk("abort_data", Data, 0);
    chk("abort_addr", Addr, 0);
    @(negedge Clock);
    Resetn = 1'b1;
    repeat (10) @(negedge Clock);
    chk("abort_selcnt", sel_cnt - base, 2);
    chk("abort_idle_busy", Busy, 0);

    // Start held high: sequences every 8 cycles
    Value = 24'h000001; Blank = 1'b1; Start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge Clock);
      chk($sformatf("held_sel_c%0d", c), Sel, ((c % 8) >= 1 && (c % 8) <= 6) ? 1 : 0);
      chk($sformatf("held_done_c%0d", c), Done, ((c % 8) == 7) ? 1 : 0);
      if ((c % 8) >= 1 && (c % 8) <= 6)
        chk($sformatf("held_addr_c%0d", c), Addr, (c % 8) - 1);
    end
    Start = 1'b0;
    repeat (12) @(negedge Clock);
    chk("held_end_sel", Sel, 0);
    chk("held_end_busy", Busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
